// File: rtl/if_fetch_if.sv
// Fetch-stage bundle: instruction-memory request/response plus the decode-side IF/ID view.
// Counter outputs exist only when IF_FETCH_PERF_CNT_EN is defined.
interface if_fetch_if;
    logic        if_fetch_stall_i;
    logic        if_fetch_jumpbranch_en_i;
    logic [63:0] if_fetch_jumpbranch_addr_i;
    logic        if_fetch_req_o;
    logic [63:0] if_fetch_addr_o;
    logic        if_fetch_ack_i;
    logic [31:0] if_fetch_rdata_i;
    logic        if_fetch_inst_valid_o;
    logic [31:0] if_fetch_inst_o;
    logic [63:0] if_fetch_inst_addr_o;
    logic [63:0] if_fetch_nxt_inst_addr_o;
`ifdef IF_FETCH_PERF_CNT_EN
    logic [63:0] if_fetch_inst_cnt_o;
    logic [63:0] if_fetch_stall_cnt_o;
`endif

    // master: the fetch unit; slave: memory plus decode around it
    modport master (
        input  if_fetch_stall_i, if_fetch_jumpbranch_en_i, if_fetch_jumpbranch_addr_i,
               if_fetch_ack_i, if_fetch_rdata_i,
        output if_fetch_req_o, if_fetch_addr_o, if_fetch_inst_valid_o, if_fetch_inst_o,
               if_fetch_inst_addr_o, if_fetch_nxt_inst_addr_o
`ifdef IF_FETCH_PERF_CNT_EN
        , output if_fetch_inst_cnt_o, if_fetch_stall_cnt_o
`endif
    );

    modport slave (
        output if_fetch_stall_i, if_fetch_jumpbranch_en_i, if_fetch_jumpbranch_addr_i,
               if_fetch_ack_i, if_fetch_rdata_i,
        input  if_fetch_req_o, if_fetch_addr_o, if_fetch_inst_valid_o, if_fetch_inst_o,
               if_fetch_inst_addr_o, if_fetch_nxt_inst_addr_o
`ifdef IF_FETCH_PERF_CNT_EN
        , input if_fetch_inst_cnt_o, if_fetch_stall_cnt_o
`endif
    );
endinterface

// File: rtl/if_fetch.sv
// Instruction fetch stage: one outstanding request, one-entry stall buffer, IF/ID register.
// Optional performance counters are enabled by defining IF_FETCH_PERF_CNT_EN.
//
// state | meaning
// IDLE  | first cycle after reset, no request outstanding
// REQ   | request driven at pc until ack
// HOLD  | response parked in buffer while decode stalls
// DROP  | redirected with a request in flight; swallow its ack
module if_fetch #(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
    input  logic          clk,
    input  logic          rst,
    if_fetch_if.master    bus
);
    typedef enum logic [1:0] {IDLE, REQ, HOLD, DROP} state_t;

    state_t      state;
    logic [63:0] pc;
    logic        req_q;
    logic        valid_q;
    logic [31:0] inst_q;
    logic [63:0] inst_addr_q;
    logic [63:0] nxt_addr_q;
    logic [31:0] buf_inst;
    logic [63:0] buf_addr;

    logic        stall;
    logic        jb_en;
    logic        ack;
    logic        redirect;
    logic [63:0] fetch_addr;
    logic        take_resp;
    logic        take_buf;
    logic        load_en;
    logic [31:0] load_inst;
    logic [63:0] load_addr;

    assign stall      = bus.if_fetch_stall_i;
    assign jb_en      = bus.if_fetch_jumpbranch_en_i;
    assign ack        = bus.if_fetch_ack_i;
    assign redirect   = jb_en & ~stall;
    assign fetch_addr = {pc[63:2], 2'b00};

    // IF/ID is written only when decode can accept and no redirect is pending
    assign take_resp  = (state == REQ)  & ack & ~stall & ~jb_en;
    assign take_buf   = (state == HOLD) & ~stall & ~jb_en;
    assign load_en    = take_resp | take_buf;
    assign load_inst  = take_buf ? buf_inst : bus.if_fetch_rdata_i;
    assign load_addr  = take_buf ? buf_addr : fetch_addr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            req_q       <= 1'b0;
            valid_q     <= 1'b0;
            inst_q      <= 32'h0000_0013;
            inst_addr_q <= 64'h0;
            nxt_addr_q  <= 64'h0;
            buf_inst    <= 32'h0;
            buf_addr    <= 64'h0;
        end else begin
            // Unstalled decode consumes IF/ID every cycle; this also flushes on redirect
            if (load_en) begin
                valid_q     <= 1'b1;
                inst_q      <= load_inst;
                inst_addr_q <= load_addr;
                nxt_addr_q  <= load_addr + 64'd4;
            end else if (!stall) begin
                valid_q <= 1'b0;
            end

            case (state)
                IDLE: begin
                    state <= REQ;
                    req_q <= 1'b1;
                    if (redirect) pc <= bus.if_fetch_jumpbranch_addr_i;
                end
                REQ: begin
                    if (redirect) begin
                        pc <= bus.if_fetch_jumpbranch_addr_i;
                        if (!ack) begin
                            state <= DROP;
                            req_q <= 1'b0;
                        end
                    end else if (ack) begin
                        pc <= pc + 64'd4;
                        if (stall) begin
                            buf_inst <= bus.if_fetch_rdata_i;
                            buf_addr <= fetch_addr;
                            state    <= HOLD;
                            req_q    <= 1'b0;
                        end
                    end
                end
                HOLD: begin
                    if (redirect) pc <= bus.if_fetch_jumpbranch_addr_i;
                    if (redirect || !stall) begin
                        state <= REQ;
                        req_q <= 1'b1;
                    end
                end
                DROP: begin
                    if (redirect) pc <= bus.if_fetch_jumpbranch_addr_i;
                    // The stale ack closes the old transaction even if a new redirect lands with it
                    if (ack) begin
                        state <= REQ;
                        req_q <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    req_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.if_fetch_req_o           = req_q;
    assign bus.if_fetch_addr_o          = fetch_addr;
    assign bus.if_fetch_inst_valid_o    = valid_q;
    assign bus.if_fetch_inst_o          = inst_q;
    assign bus.if_fetch_inst_addr_o     = inst_addr_q;
    assign bus.if_fetch_nxt_inst_addr_o = nxt_addr_q;

`ifdef IF_FETCH_PERF_CNT_EN
    logic [63:0] inst_cnt;
    logic [63:0] stall_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inst_cnt  <= 64'h0;
            stall_cnt <= 64'h0;
        end else begin
            if (load_en) inst_cnt  <= inst_cnt + 64'd1;
            if (stall)   stall_cnt <= stall_cnt + 64'd1;
        end
    end

    assign bus.if_fetch_inst_cnt_o  = inst_cnt;
    assign bus.if_fetch_stall_cnt_o = stall_cnt;
`endif
endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: per-cycle vector table, scoreboarded random stream,
// reset corner cases, and counter check when IF_FETCH_PERF_CNT_EN is defined.
module tb_if_fetch;
    localparam logic [63:0] R  = 64'h0000_0000_8000_0000;
    localparam logic [63:0] T  = 64'h0000_0000_8000_0100;
    localparam logic [31:0] I0 = 32'h0010_0093;
    localparam logic [31:0] I1 = 32'h0020_0093;
    localparam logic [31:0] I2 = 32'h0030_0093;
    localparam logic [31:0] IA = 32'h00A0_0093;
    localparam logic [31:0] I3 = 32'h0040_0093;
    localparam logic [31:0] I4 = 32'h0050_0093;
    localparam logic [31:0] I5 = 32'h0060_0093;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst = 1'b0;
    if_fetch_if bus();

    if_fetch #(.RESET_PC(R)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic        ack;
        logic [31:0] rdata;
        logic        stall;
        logic        jb;
        logic [63:0] jaddr;
        logic        e_req;
        logic [63:0] e_addr;
        logic        e_valid;
        logic [31:0] e_inst;
        logic [63:0] e_iaddr;
    } vec_t;

    typedef struct {
        logic [31:0] inst;
        logic [63:0] addr;
    } sb_t;

    vec_t tbl[16];
    sb_t  sbq[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic ack, input logic [31:0] rdata, input logic stall,
                         input logic jb, input logic [63:0] jaddr);
        bus.if_fetch_ack_i             = ack;
        bus.if_fetch_rdata_i           = rdata;
        bus.if_fetch_stall_i           = stall;
        bus.if_fetch_jumpbranch_en_i   = jb;
        bus.if_fetch_jumpbranch_addr_i = jaddr;
    endtask

    function automatic vec_t mk(input logic ack, input logic [31:0] rdata, input logic stall,
                                input logic jb, input logic [63:0] jaddr, input logic e_req,
                                input logic [63:0] e_addr, input logic e_valid,
                                input logic [31:0] e_inst, input logic [63:0] e_iaddr);
        vec_t v;
        v.ack = ack; v.rdata = rdata; v.stall = stall; v.jb = jb; v.jaddr = jaddr;
        v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid;
        v.e_inst = e_inst; v.e_iaddr = e_iaddr;
        return v;
    endfunction

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return a[31:0] ^ 32'h5A5A_0013;
    endfunction

    task automatic wait_req(input string name);
        int k;
        k = 0;
        while (bus.if_fetch_req_o !== 1'b1 && k < 10) begin
            @(negedge clk);
            k++;
        end
        chk(name, {63'h0, bus.if_fetch_req_o}, 64'h1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] model_pc;
        logic        prev_stall;
        logic        st;
        logic        a;
        logic [31:0] rd;
        sb_t         e;

        drive(1'b0, 32'h0, 1'b0, 1'b0, 64'h0);

        // Row: inputs applied at this negedge, expectations checked before applying them.
        tbl[0]  = mk(0, 32'h0,        0, 0, 64'h0,          0, R,        0, NOP, 64'h0);
        tbl[1]  = mk(1, I0,           0, 0, 64'h0,          1, R,        0, NOP, 64'h0);
        tbl[2]  = mk(1, I1,           0, 0, 64'h0,          1, R + 4,    1, I0,  R);
        tbl[3]  = mk(1, I2,           0, 0, 64'h0,          1, R + 8,    1, I1,  R + 4);
        tbl[4]  = mk(1, IA,           1, 0, 64'h0,          1, R + 12,   1, I2,  R + 8);
        tbl[5]  = mk(0, 32'h0,        1, 0, 64'h0,          0, R + 16,   1, I2,  R + 8);
        tbl[6]  = mk(0, 32'h0,        0, 0, 64'h0,          0, R + 16,   1, I2,  R + 8);
        tbl[7]  = mk(1, I3,           0, 0, 64'h0,          1, R + 16,   1, IA,  R + 12);
        tbl[8]  = mk(0, 32'h0,        0, 1, T,              1, R + 20,   1, I3,  R + 16);
        tbl[9]  = mk(1, 32'hDEAD_BEEF,0, 0, 64'h0,          0, T,        0, I3,  R + 16);
        tbl[10] = mk(1, I4,           0, 0, 64'h0,          1, T,        0, I3,  R + 16);
        tbl[11] = mk(0, 32'h0,        1, 1, 64'h9000_0000,  1, T + 4,    1, I4,  T);
        tbl[12] = mk(1, I5,           0, 0, 64'h0,          1, T + 4,    1, I4,  T);
        tbl[13] = mk(1, 32'hBAD0_0BAD,0, 1, R,              1, T + 8,    1, I5,  T + 4);
        tbl[14] = mk(0, 32'h0,        0, 0, 64'h0,          1, R,        0, I5,  T + 4);
        tbl[15] = mk(0, 32'h0,        0, 0, 64'h0,          1, R,        0, I5,  T + 4);

        repeat (3) @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 16; i++) begin
            chk($sformatf("v%0d_req", i),   {63'h0, bus.if_fetch_req_o},       {63'h0, tbl[i].e_req});
            chk($sformatf("v%0d_addr", i),  bus.if_fetch_addr_o,               tbl[i].e_addr);
            chk($sformatf("v%0d_valid", i), {63'h0, bus.if_fetch_inst_valid_o},{63'h0, tbl[i].e_valid});
            chk($sformatf("v%0d_inst", i),  {32'h0, bus.if_fetch_inst_o},      {32'h0, tbl[i].e_inst});
            chk($sformatf("v%0d_iaddr", i), bus.if_fetch_inst_addr_o,          tbl[i].e_iaddr);
            chk($sformatf("v%0d_nxt", i),   bus.if_fetch_nxt_inst_addr_o,
                (tbl[i].e_iaddr == 64'h0) ? 64'h0 : tbl[i].e_iaddr + 64'd4);
            drive(tbl[i].ack, tbl[i].rdata, tbl[i].stall, tbl[i].jb, tbl[i].jaddr);
            @(negedge clk);
        end

        // Random ack/stall stream, no redirects; table left the fetcher in REQ at R.
        drive(1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
        @(negedge clk);
        model_pc   = R;
        prev_stall = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (!prev_stall && bus.if_fetch_inst_valid_o === 1'b1) begin
                if (sbq.size() == 0) begin
                    chk("sb_unexpected_valid", {63'h0, bus.if_fetch_inst_valid_o}, 64'h0);
                end else begin
                    e = sbq.pop_front();
                    chk("sb_inst",  {32'h0, bus.if_fetch_inst_o}, {32'h0, e.inst});
                    chk("sb_iaddr", bus.if_fetch_inst_addr_o, e.addr);
                    chk("sb_nxt",   bus.if_fetch_nxt_inst_addr_o, e.addr + 64'd4);
                end
            end
            if (bus.if_fetch_req_o === 1'b1) chk("sb_addr", bus.if_fetch_addr_o, model_pc);
            st = ($urandom_range(0, 3) == 0);
            a  = (bus.if_fetch_req_o === 1'b1) && ($urandom_range(0, 2) != 0);
            rd = 32'h0;
            if (a) begin
                rd = mem_word(model_pc);
                e.inst = rd;
                e.addr = model_pc;
                sbq.push_back(e);
                model_pc = model_pc + 64'd4;
            end
            drive(a, rd, st, 1'b0, 64'h0);
            prev_stall = st;
            @(negedge clk);
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
        for (int c = 0; c < 6 && sbq.size() != 0; c++) begin
            if (!prev_stall && bus.if_fetch_inst_valid_o === 1'b1) begin
                e = sbq.pop_front();
                chk("drain_inst",  {32'h0, bus.if_fetch_inst_o}, {32'h0, e.inst});
                chk("drain_iaddr", bus.if_fetch_inst_addr_o, e.addr);
            end
            prev_stall = 1'b0;
            @(negedge clk);
        end
        chk("sb_leftover", sbq.size(), 64'h0);

        // Reset in the middle of a request, then a stale ack right after release.
        wait_req("rst_pre_req");
        rst = 1'b0;
        #1;
        chk("rst_req",   {63'h0, bus.if_fetch_req_o}, 64'h0);
        chk("rst_inst",  {32'h0, bus.if_fetch_inst_o}, {32'h0, NOP});
        chk("rst_valid", {63'h0, bus.if_fetch_inst_valid_o}, 64'h0);
        chk("rst_iaddr", bus.if_fetch_inst_addr_o, 64'h0);
        chk("rst_nxt",   bus.if_fetch_nxt_inst_addr_o, 64'h0);
        chk("rst_addr",  bus.if_fetch_addr_o, R);
        @(negedge clk);
        @(negedge clk);
        drive(1'b1, 32'hBAD0_0BAD, 1'b0, 1'b0, 64'h0);
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_req",   {63'h0, bus.if_fetch_req_o}, 64'h1);
        chk("post_rst_addr",  bus.if_fetch_addr_o, R);
        chk("post_rst_valid", {63'h0, bus.if_fetch_inst_valid_o}, 64'h0);
        drive(1'b1, I0, 1'b0, 1'b0, 64'h0);
        @(negedge clk);
        chk("post_rst_inst",  {32'h0, bus.if_fetch_inst_o}, {32'h0, I0});
        chk("post_rst_iaddr", bus.if_fetch_inst_addr_o, R);
        chk("post_rst_v",     {63'h0, bus.if_fetch_inst_valid_o}, 64'h1);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 64'h0);

`ifdef IF_FETCH_PERF_CNT_EN
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        wait_req("cnt_req");
        for (int k = 0; k < 10; k++) begin
            drive(1'b1, mem_word(R + 64'(4 * k)), 1'b0, 1'b0, 64'h0);
            @(negedge clk);
        end
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 32'h0, 1'b1, 1'b0, 64'h0);
            @(negedge clk);
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
        @(negedge clk);
        chk("inst_cnt",  bus.if_fetch_inst_cnt_o,  64'd10);
        chk("stall_cnt", bus.if_fetch_stall_cnt_o, 64'd3);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
